// File: rtl/mem_arbiter.sv
// Two-requester (IFU/LSU) arbiter in front of a single-port memory, one transaction in flight.
// Define ARB_RR_EN for round-robin arbitration; the default build uses fixed LSU priority.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    ifu_req_valid_i,
  output logic                    ifu_req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   ifu_addr_i,
  output logic                    ifu_resp_valid_o,
  input  logic                    ifu_resp_ready_i,
  output logic [DATA_WIDTH-1:0]   ifu_rdata_o,
  output logic                    ifu_err_o,
  input  logic                    lsu_req_valid_i,
  output logic                    lsu_req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   lsu_addr_i,
  input  logic                    lsu_wen_i,
  input  logic [DATA_WIDTH-1:0]   lsu_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] lsu_wmask_i,
  output logic                    lsu_resp_valid_o,
  input  logic                    lsu_resp_ready_i,
  output logic [DATA_WIDTH-1:0]   lsu_rdata_o,
  output logic                    lsu_err_o,
  output logic                    mem_req_valid_o,
  input  logic                    mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_wen_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_wmask_o,
  input  logic                    mem_resp_valid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic                    busy_o
);

  localparam int MW = DATA_WIDTH / 8;
  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

  state_e                state_q;
  logic                  owner_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  wen_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [MW-1:0]         wmask_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic [15:0]           wdog_q;

  logic grant_lsu;
  logic accept;
  logic resp_done;

  // owner_q / grant_lsu: 1 selects the LSU, 0 the IFU
`ifdef ARB_RR_EN
  logic last_grant_q;
  assign grant_lsu = lsu_req_valid_i && (!ifu_req_valid_i || !last_grant_q);
`else
  assign grant_lsu = lsu_req_valid_i;
`endif

  assign accept          = (state_q == S_IDLE) && !rst_i && (ifu_req_valid_i || lsu_req_valid_i);
  assign ifu_req_ready_o = accept && !grant_lsu;
  assign lsu_req_ready_o = accept && grant_lsu;
  assign resp_done       = owner_q ? lsu_resp_ready_i : ifu_resp_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      wdog_q  <= '0;
`ifdef ARB_RR_EN
      last_grant_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            owner_q <= grant_lsu;
            addr_q  <= grant_lsu ? lsu_addr_i : ifu_addr_i;
            wen_q   <= grant_lsu && lsu_wen_i;
            wdata_q <= grant_lsu ? lsu_wdata_i : '0;
            wmask_q <= grant_lsu ? lsu_wmask_i : '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            state_q <= S_REQ;
`ifdef ARB_RR_EN
            last_grant_q <= grant_lsu;
`endif
          end
        end
        S_REQ: begin
          if (mem_req_ready_i) begin
            wdog_q  <= '0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A response arriving in the last watchdog cycle still wins over the timeout
          if (mem_resp_valid_i) begin
            rdata_q <= wen_q ? '0 : mem_rdata_i;
            state_q <= S_RESP;
          end else if (wdog_q == WDOG_LAST) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
            state_q <= S_RESP;
          end else begin
            wdog_q <= wdog_q + 16'd1;
          end
        end
        S_RESP: begin
          if (resp_done) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ifu_resp_valid_o = (state_q == S_RESP) && !owner_q;
  assign lsu_resp_valid_o = (state_q == S_RESP) && owner_q;
  assign ifu_rdata_o      = ifu_resp_valid_o ? rdata_q : '0;
  assign lsu_rdata_o      = lsu_resp_valid_o ? rdata_q : '0;
  assign ifu_err_o        = ifu_resp_valid_o && err_q;
  assign lsu_err_o        = lsu_resp_valid_o && err_q;

  assign mem_req_valid_o = (state_q == S_REQ);
  assign mem_addr_o      = addr_q;
  assign mem_wen_o       = wen_q;
  assign mem_wdata_o     = wdata_q;
  assign mem_wmask_o     = wmask_q;
  assign busy_o          = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then random traffic, checked against a
// transaction-level model of pending requests, arbitration order and expected responses.
module tb_mem_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifuReqValid, ifuReqReady, ifuRespValid, ifuRespReady, ifuErr;
  logic [31:0] ifuAddr, ifuRdata;
  logic        lsuReqValid, lsuReqReady, lsuWen, lsuRespValid, lsuRespReady, lsuErr;
  logic [31:0] lsuAddr, lsuWdata, lsuRdata;
  logic [3:0]  lsuWmask;
  logic        memReqValid, memReqReady, memWen, memRespValid, busy;
  logic [31:0] memAddr, memWdata, memRdata;
  logic [3:0]  memWmask;

  int checks = 0;
  int errors = 0;

  // Requests the model believes are outstanding, and the last side granted (1 = LSU)
  bit          ifuPend = 0, lsuPend = 0, lastWasLsu = 0;
  logic [31:0] ifuAddrP, lsuAddrP, lsuWdataP;
  logic        lsuWenP;
  logic [3:0]  lsuWmaskP;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .ifu_req_valid_i(ifuReqValid), .ifu_req_ready_o(ifuReqReady), .ifu_addr_i(ifuAddr),
    .ifu_resp_valid_o(ifuRespValid), .ifu_resp_ready_i(ifuRespReady),
    .ifu_rdata_o(ifuRdata), .ifu_err_o(ifuErr),
    .lsu_req_valid_i(lsuReqValid), .lsu_req_ready_o(lsuReqReady), .lsu_addr_i(lsuAddr),
    .lsu_wen_i(lsuWen), .lsu_wdata_i(lsuWdata), .lsu_wmask_i(lsuWmask),
    .lsu_resp_valid_o(lsuRespValid), .lsu_resp_ready_i(lsuRespReady),
    .lsu_rdata_o(lsuRdata), .lsu_err_o(lsuErr),
    .mem_req_valid_o(memReqValid), .mem_req_ready_i(memReqReady), .mem_addr_o(memAddr),
    .mem_wen_o(memWen), .mem_wdata_o(memWdata), .mem_wmask_o(memWmask),
    .mem_resp_valid_i(memRespValid), .mem_rdata_i(memRdata), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit pickWinner();
    if (ifuPend && lsuPend) begin
`ifdef ARB_RR_EN
      return !lastWasLsu;
`else
      return 1'b1;
`endif
    end
    return lsuPend;
  endfunction

  task automatic newLsu(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] m);
    lsuPend = 1; lsuAddrP = a; lsuWenP = w; lsuWdataP = d; lsuWmaskP = m;
  endtask

  // One full transaction from the IDLE cycle through the response handshake.
  // respDelay < 0 means memory never answers; lateReq raises the other side once busy.
  task automatic applyStimulus(input int grantDelay, input int respDelay, input int readyDelay,
                               input logic [31:0] memData, input bit lateReq);
    bit          winLsu, eTimeout;
    logic [31:0] eAddr, eWdata, eRdata, held;
    logic        eWen;
    logic [3:0]  eMask;
    int          waitCycles;
    ifuReqValid = ifuPend; ifuAddr = ifuAddrP;
    lsuReqValid = lsuPend; lsuAddr = lsuAddrP; lsuWen = lsuWenP;
    lsuWdata = lsuWdataP; lsuWmask = lsuWmaskP;
    #1;
    winLsu = pickWinner();
    checkOutput("idle_busy", busy, 0);
    checkOutput("ifu_req_ready", ifuReqReady, !winLsu);
    checkOutput("lsu_req_ready", lsuReqReady, winLsu);
    eAddr  = winLsu ? lsuAddrP : ifuAddrP;
    eWen   = winLsu ? lsuWenP : 1'b0;
    eWdata = winLsu ? lsuWdataP : 32'h0;
    eMask  = winLsu ? lsuWmaskP : 4'h0;
    lastWasLsu = winLsu;
    if (winLsu) lsuPend = 0; else ifuPend = 0;
    tick();
    if (winLsu) begin
      lsuReqValid = 0; lsuAddr = $urandom; lsuWdata = $urandom; lsuWmask = 4'($urandom);
    end else begin
      ifuReqValid = 0; ifuAddr = $urandom;
    end
    if (lateReq && winLsu && !ifuPend) begin
      ifuPend = 1; ifuAddrP = $urandom; ifuReqValid = 1; ifuAddr = ifuAddrP;
    end else if (lateReq && !winLsu && !lsuPend) begin
      newLsu($urandom, 1'($urandom), $urandom, 4'($urandom));
      lsuReqValid = 1; lsuAddr = lsuAddrP; lsuWen = lsuWenP;
      lsuWdata = lsuWdataP; lsuWmask = lsuWmaskP;
    end
    for (int g = 0; g <= grantDelay; g++) begin
      memReqReady = (g == grantDelay);
      memRespValid = (g == 0);
      memRdata = $urandom;
      checkOutput("req_mem_valid", memReqValid, 1);
      checkOutput("req_payload", {memAddr, memWdata}, {eAddr, eWdata});
      checkOutput("req_wen_mask", {memWen, memWmask}, {eWen, eMask});
      checkOutput("req_readys", {ifuReqReady, lsuReqReady, ifuRespValid, lsuRespValid}, 0);
      tick();
    end
    memReqReady = 0;
    eTimeout = (respDelay < 0) || (respDelay >= TO);
    waitCycles = eTimeout ? TO : respDelay + 1;
    for (int w = 0; w < waitCycles; w++) begin
      memRespValid = (w == respDelay);
      memRdata = memRespValid ? memData : $urandom;
      checkOutput("wait_state", {busy, memReqValid, ifuRespValid, lsuRespValid}, 4'b1000);
      tick();
    end
    memRespValid = 0;
    eRdata = (eTimeout || eWen) ? 32'h0 : memData;
    for (int r = 0; r <= readyDelay; r++) begin
      if (winLsu) begin
        lsuRespReady = (r == readyDelay); ifuRespReady = 1'($urandom);
      end else begin
        ifuRespReady = (r == readyDelay); lsuRespReady = 1'($urandom);
      end
      memRespValid = (r == 0);
      memRdata = $urandom;
      checkOutput("resp_valids", {ifuRespValid, lsuRespValid}, {!winLsu, winLsu});
      held = winLsu ? lsuRdata : ifuRdata;
      checkOutput("resp_rdata", held, eRdata);
      checkOutput("resp_err", {ifuErr, lsuErr}, {!winLsu && eTimeout, winLsu && eTimeout});
      checkOutput("resp_other_rdata", winLsu ? ifuRdata : lsuRdata, 0);
      checkOutput("resp_no_accept", {ifuReqReady, lsuReqReady, busy}, 3'b001);
      tick();
    end
    memRespValid = 0; ifuRespReady = 0; lsuRespReady = 0;
    checkOutput("done_idle", {busy, ifuRespValid, lsuRespValid}, 0);
  endtask

  initial begin
    rst = 1;
    ifuReqValid = 0; ifuAddr = 0; ifuRespReady = 0;
    lsuReqValid = 0; lsuAddr = 0; lsuWen = 0; lsuWdata = 0; lsuWmask = 0; lsuRespReady = 0;
    memReqReady = 0; memRespValid = 0; memRdata = 0;
    ifuAddrP = 0; lsuAddrP = 0; lsuWenP = 0; lsuWdataP = 0; lsuWmaskP = 0;
    tick(); tick();
    checkOutput("reset_valids", {busy, memReqValid, ifuRespValid, lsuRespValid}, 0);
    checkOutput("reset_data", {memAddr, ifuRdata, lsuRdata, memWdata}, 0);
    checkOutput("reset_misc", {ifuErr, lsuErr, memWen, memWmask, ifuReqReady, lsuReqReady}, 0);
    rst = 0;

    $display("[TB] IFU-only fetch");
    ifuPend = 1; ifuAddrP = 32'h80000000;
    applyStimulus(0, 0, 0, 32'h00000413, 0);

    $display("[TB] simultaneous requests");
    ifuPend = 1; ifuAddrP = 32'h80000004;
    newLsu(32'h80001000, 0, 32'h0, 4'h0);
    applyStimulus(0, 0, 0, 32'h11111111, 0);
    applyStimulus(0, 0, 0, 32'h22222222, 0);
    ifuPend = 1; ifuAddrP = 32'h80000008;
    newLsu(32'h80001004, 0, 32'h0, 4'h0);
    applyStimulus(0, 1, 0, 32'h33333333, 0);
    newLsu(32'h80001008, 0, 32'h0, 4'h0);
    applyStimulus(0, 0, 1, 32'h44444444, 0);
    applyStimulus(1, 0, 0, 32'h55555555, 0);

    $display("[TB] store");
    newLsu(32'h80001000, 1, 32'hdeadbeef, 4'b0001);
    applyStimulus(1, 2, 0, 32'h12345678, 0);

    $display("[TB] timeout and last-cycle response");
    ifuPend = 1; ifuAddrP = 32'h8000000c;
    applyStimulus(0, -1, 1, 32'hcafef00d, 0);
    ifuPend = 1; ifuAddrP = 32'h80000010;
    applyStimulus(0, TO - 1, 0, 32'h0a0b0c0d, 0);

    $display("[TB] reset during WAIT");
    ifuReqValid = 1; ifuAddr = 32'h80000014;
    #1;
    checkOutput("rst_pre_accept", ifuReqReady, 1);
    tick();
    ifuReqValid = 0; memReqReady = 1;
    tick();
    memReqReady = 0;
    tick(); tick();
    checkOutput("rst_in_wait", {busy, memReqValid}, 2'b10);
    rst = 1; lsuReqValid = 1; lsuAddr = 32'h80002000;
    tick();
    lastWasLsu = 0;
    checkOutput("rst_outputs", {busy, memReqValid, ifuRespValid, lsuRespValid, lsuReqReady}, 0);
    checkOutput("rst_payload", {memAddr, memWen, memWmask, ifuErr, ifuRdata}, 0);
    rst = 0; lsuReqValid = 0; memRespValid = 1; memRdata = 32'hbadbadba;
    tick();
    memRespValid = 0;
    checkOutput("stale_resp_ignored", {busy, ifuRespValid, lsuRespValid}, 0);
    ifuPend = 1; ifuAddrP = 32'h80000018;
    applyStimulus(0, 1, 0, 32'h00100093, 0);

    $display("[TB] stalled IFU response with LSU waiting");
    ifuPend = 1; ifuAddrP = 32'h8000001c;
    applyStimulus(0, 0, 5, 32'h0badc0de, 1);
    applyStimulus(0, 0, 0, 32'h77777777, 0);

    $display("[TB] random traffic");
    for (int i = 0; i < 40; i++) begin
      if (!ifuPend && $urandom_range(0, 1) == 1) begin
        ifuPend = 1; ifuAddrP = $urandom;
      end
      if (!lsuPend && $urandom_range(0, 1) == 1)
        newLsu($urandom, 1'($urandom), $urandom, 4'($urandom));
      if (!ifuPend && !lsuPend) begin
        ifuPend = 1; ifuAddrP = $urandom;
      end
      applyStimulus($urandom_range(0, 2), int'($urandom_range(0, 10)) - 1,
                    $urandom_range(0, 2), $urandom, 1'($urandom));
    end

    ifuReqValid = 0; lsuReqValid = 0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
